projectile_pool: RTL and testbench
==================================

Name: projectile_pool

Overview:
- Parametrised launcher and lifetime manager for SLOTS concurrent projectiles (torpedos).
- Replaces the cascaded per-torpedo fire chain with one central allocator. It tracks per-slot lifetime and fire cooldown and captures the ship pose at launch.
- Sits between the periphery fire button and the per-slot torpedo draw/motion units. Frame timing comes from the one-cycle vsync-rise pulse.

Parameters:
SLOTS, 4, number of concurrent projectile slots (1..16)
LIFE_FRAMES, 60, frames a projectile stays active if not hit (>=1)
COOLDOWN_FRAMES, 6, frames after a launch before the next launch is permitted (>=0)
X_W, 10, ship x coordinate width
Y_W, 9, ship y coordinate width

Ports:
clk  in  1  system clock (25 MHz pixel clock domain)
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame (vsync rising edge)
fire  in  1  fire button level, already synchronised
ship_x  in  X_W  ship centre x, sampled at launch
ship_y  in  Y_W  ship centre y, sampled at launch
sin_val  in  18 signed  ship heading sine, sampled at launch
cos_val  in  18 signed  ship heading cosine, sampled at launch
hit  in  SLOTS  per-slot kill request (collision); one-cycle pulses or levels
active  out  SLOTS  slot is in flight
launch  out  SLOTS  one-cycle pulse: slot k was just launched
expired  out  SLOTS  one-cycle pulse: slot k retired by lifetime end
launch_x  out  X_W  ship_x captured at the most recent launch
launch_y  out  Y_W  ship_y captured at the most recent launch
launch_sin  out  18  sin_val captured at the most recent launch
launch_cos  out  18  cos_val captured at the most recent launch
free_count  out  clog2(SLOTS+1)  number of idle slots
full  out  1  all slots active

Behaviour:
- Reset values:
  - active, launch, expired, all life counters, cooldown, armed and fire_d = 0.
  - launch_x/y/sin/cos = 0.
  - free_count = SLOTS; full = 0.
- Reset mid-flight kills all slots immediately, with no expired pulses.
- Fire edge detect:
  - fire_d <= fire.
  - armed sets on fire & ~fire_d.
  - armed clears on a launch or when fire = 0.
- Launch condition, evaluated every cycle: req & (cooldown == 0) & ~full.
  - req = armed (see Optional Feature).
  - Selected slot k is the lowest-index idle slot (priority encoder on ~active).
- On a launch at edge N:
  - active[k] = 1 and launch[k] = 1 for exactly one cycle after edge N.
  - launch_* registers load the inputs sampled at edge N.
  - life[k] = LIFE_FRAMES; cooldown = COOLDOWN_FRAMES.
  - Latency from fire rising to launch pulse: 1 cycle after fire is first sampled high (fire_d path), i.e. 2 edges.
- Lifetime, on frame_tick:
  - Each active slot not launched this cycle with life > 1 decrements.
  - A slot with life == 1 retires: active = 0, expired[k] = 1 for one cycle.
  - A slot therefore lives exactly LIFE_FRAMES frame_ticks.
  - Launch coinciding with frame_tick: the new slot is loaded and not decremented.
- Cooldown: decrements on frame_tick while > 0. A launch coinciding with frame_tick loads COOLDOWN_FRAMES without decrementing.
- Hit handling:
  - hit[k] on an active slot clears it next edge and clears its life counter. No expired pulse.
  - Hit and expiry in the same cycle: hit wins, so expired stays 0.
  - hit[k] on an idle slot is ignored.
  - A slot freed by hit in cycle N is not reusable for a launch evaluated in cycle N; it is eligible from N+1.
- Full pool: fire requests are held while armed. The launch occurs as soon as a slot frees, provided fire is still high and cooldown == 0.
- Outputs are registered: free_count = popcount(~active) and full = &active, both consistent with active in the same cycle.
- Only one launch per cycle, ever.

Optional Feature:
- Macro: PROJECTILE_AUTOFIRE_EN.
- Defined: req = fire. Holding fire relaunches every time cooldown reaches 0 and a slot is free. armed is unused.
  - COOLDOWN_FRAMES = 0 with fire held: one launch per cycle until full.
- Undefined: req = armed. Each launch needs a new rising edge of fire.

Test Plan:
- Reset, then idle 5 frames -> active=0, free_count=4, full=0; no launch/expired pulses.
- fire 0->1 with ship_x=320, ship_y=240, sin=0, cos=0x1FFFF -> launch=4'b0001 one cycle 2 edges later; launch_x=320, launch_y=240; active=4'b0001; free_count=3.
- Launch, then 60 frame_ticks with no hit -> expired[0] pulses on the 60th tick; active[0]=0; free_count back to 4.
- Fill all 4 slots with 4 presses spaced >6 frames, then press again -> no launch, full=1. Pulse hit[2] while fire stays high -> slot 2 relaunched, launch=4'b0100.
- hit[1] asserted in the same cycle as slot 1's final frame_tick -> active[1]=0, expired[1] never pulses.
- PROJECTILE_AUTOFIRE_EN defined, fire held 30 frames, COOLDOWN_FRAMES=6 -> launches at frames 0, 6, 12, 18; then full=1 and no further launches. Undefined: a single launch only.

Source files
------------

// File: rtl/projectile_pool.sv
// Central launcher / lifetime manager for SLOTS projectiles: edge-triggered fire,
// per-slot frame lifetime, launch cooldown and ship pose capture. Optional macro: PROJECTILE_AUTOFIRE_EN.
module projectile_pool #(
  parameter int SLOTS           = 4,
  parameter int LIFE_FRAMES     = 60,
  parameter int COOLDOWN_FRAMES = 6,
  parameter int X_W             = 10,
  parameter int Y_W             = 9
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic                           fire,
  input  logic [X_W-1:0]                 ship_x,
  input  logic [Y_W-1:0]                 ship_y,
  input  logic signed [17:0]             sin_val,
  input  logic signed [17:0]             cos_val,
  input  logic [SLOTS-1:0]               hit,
  output logic [SLOTS-1:0]               active,
  output logic [SLOTS-1:0]               launch,
  output logic [SLOTS-1:0]               expired,
  output logic [X_W-1:0]                 launch_x,
  output logic [Y_W-1:0]                 launch_y,
  output logic signed [17:0]             launch_sin,
  output logic signed [17:0]             launch_cos,
  output logic [$clog2(SLOTS+1)-1:0]     free_count,
  output logic                           full
);

  localparam int CNT_W  = $clog2(SLOTS + 1);
  localparam int LIFE_W = $clog2(LIFE_FRAMES + 1);
  localparam int CD_W   = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  logic [SLOTS-1:0]   active_q, active_d;
  logic [SLOTS-1:0]   launch_q, expired_q, expired_d;
  logic [SLOTS-1:0]   launch_sel, launch_oh;
  logic [CNT_W-1:0]   free_count_q, free_count_d;
  logic               full_q;
  logic [CD_W-1:0]    cooldown_q, cooldown_d;
  logic [X_W-1:0]     launch_x_q;
  logic [Y_W-1:0]     launch_y_q;
  logic signed [17:0] launch_sin_q, launch_cos_q;
  logic               req;
  logic               launch_go;

`ifdef PROJECTILE_AUTOFIRE_EN
  assign req = fire;
`else
  logic fire_d_q;
  logic armed_q, armed_d;

  // A request stays armed across a full pool until it launches or fire drops.
  always_comb begin
    armed_d = armed_q;
    if (launch_go)
      armed_d = 1'b0;
    else if (fire && !fire_d_q)
      armed_d = 1'b1;
    else if (!fire)
      armed_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_d_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      fire_d_q <= fire;
      armed_q  <= armed_d;
    end
  end

  assign req = armed_q;
`endif

  assign launch_go = req && (cooldown_q == '0) && !full_q;

  // Lowest-index idle slot; slots freed this cycle are still seen as busy.
  always_comb begin
    logic found;
    launch_sel = '0;
    found      = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!active_q[i] && !found) begin
        launch_sel[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  assign launch_oh = launch_go ? launch_sel : '0;

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    logic [LIFE_W-1:0] life_q, life_d;
    logic              retire;

    always_comb begin
      life_d = life_q;
      retire = 1'b0;
      if (launch_oh[gi]) begin
        life_d = LIFE_W'(LIFE_FRAMES);
      end else if (active_q[gi] && hit[gi]) begin
        life_d = '0;
      end else if (active_q[gi] && frame_tick) begin
        if (life_q == LIFE_W'(1)) begin
          life_d = '0;
          retire = 1'b1;
        end else begin
          life_d = life_q - LIFE_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset)
        life_q <= '0;
      else
        life_q <= life_d;
    end

    assign active_d[gi]  = launch_oh[gi] | (active_q[gi] & ~hit[gi] & ~retire);
    assign expired_d[gi] = retire;
  end

  always_comb begin
    cooldown_d = cooldown_q;
    if (launch_go)
      cooldown_d = CD_W'(COOLDOWN_FRAMES);
    else if (frame_tick && (cooldown_q != '0))
      cooldown_d = cooldown_q - CD_W'(1);
  end

  always_comb begin
    free_count_d = '0;
    for (int i = 0; i < SLOTS; i++)
      free_count_d = free_count_d + CNT_W'(!active_d[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q     <= '0;
      launch_q     <= '0;
      expired_q    <= '0;
      free_count_q <= CNT_W'(SLOTS);
      full_q       <= 1'b0;
      cooldown_q   <= '0;
      launch_x_q   <= '0;
      launch_y_q   <= '0;
      launch_sin_q <= '0;
      launch_cos_q <= '0;
    end else begin
      active_q     <= active_d;
      launch_q     <= launch_oh;
      expired_q    <= expired_d;
      free_count_q <= free_count_d;
      full_q       <= &active_d;
      cooldown_q   <= cooldown_d;
      if (launch_go) begin
        launch_x_q   <= ship_x;
        launch_y_q   <= ship_y;
        launch_sin_q <= sin_val;
        launch_cos_q <= cos_val;
      end
    end
  end

  assign active     = active_q;
  assign launch     = launch_q;
  assign expired    = expired_q;
  assign free_count = free_count_q;
  assign full       = full_q;
  assign launch_x   = launch_x_q;
  assign launch_y   = launch_y_q;
  assign launch_sin = launch_sin_q;
  assign launch_cos = launch_cos_q;

endmodule

// File: tb/tb_projectile_pool.sv
// Testbench for projectile_pool: directed scenarios plus randomized traffic checked
// cycle by cycle against a slot-array reference model.
module tb_projectile_pool;
  localparam int SLOTS = 4;
  localparam int LIFE  = 60;
  localparam int CD    = 6;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam int VEC_W = 3*SLOTS + CNT_W + 1 + X_W + Y_W + 36;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 frame_tick = 1'b0;
  logic                 fire = 1'b0;
  logic [X_W-1:0]       ship_x = '0;
  logic [Y_W-1:0]       ship_y = '0;
  logic signed [17:0]   sin_val = '0;
  logic signed [17:0]   cos_val = '0;
  logic [SLOTS-1:0]     hit = '0;
  logic [SLOTS-1:0]     active, launch, expired;
  logic [X_W-1:0]       launch_x;
  logic [Y_W-1:0]       launch_y;
  logic signed [17:0]   launch_sin, launch_cos;
  logic [CNT_W-1:0]     free_count;
  logic                 full;

  int checks = 0;
  int errors = 0;

  projectile_pool #(
    .SLOTS(SLOTS), .LIFE_FRAMES(LIFE), .COOLDOWN_FRAMES(CD), .X_W(X_W), .Y_W(Y_W)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .fire(fire),
    .ship_x(ship_x), .ship_y(ship_y), .sin_val(sin_val), .cos_val(cos_val),
    .hit(hit), .active(active), .launch(launch), .expired(expired),
    .launch_x(launch_x), .launch_y(launch_y), .launch_sin(launch_sin),
    .launch_cos(launch_cos), .free_count(free_count), .full(full)
  );

  always #20 clk = ~clk;

  // Reference model: remaining frames per slot (0 = idle) plus pool-wide state.
  int                 m_life [SLOTS];
  int                 m_cd;
  bit                 m_armed, m_fire_prev;
  bit [SLOTS-1:0]     m_launch, m_expired;
  logic [X_W-1:0]     m_lx;
  logic [Y_W-1:0]     m_ly;
  logic signed [17:0] m_ls, m_lc;

  function automatic bit [SLOTS-1:0] m_active();
    bit [SLOTS-1:0] a = '0;
    for (int i = 0; i < SLOTS; i++) a[i] = (m_life[i] > 0);
    return a;
  endfunction

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) if (m_life[i] == 0) n++;
    return n;
  endfunction

  task automatic model_step();
    bit go, req;
    int k;
    m_launch  = '0;
    m_expired = '0;
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) m_life[i] = 0;
      m_cd = 0; m_armed = 0; m_fire_prev = 0;
      m_lx = '0; m_ly = '0; m_ls = '0; m_lc = '0;
      return;
    end
`ifdef PROJECTILE_AUTOFIRE_EN
    req = fire;
`else
    req = m_armed;
`endif
    go = req && (m_cd == 0) && (m_free() != 0);
    k = -1;
    for (int i = 0; i < SLOTS; i++) if (k < 0 && m_life[i] == 0) k = i;
    for (int i = 0; i < SLOTS; i++) begin
      if (go && i == k) begin
        m_life[i] = LIFE;
        m_launch[i] = 1'b1;
      end else if (m_life[i] > 0 && hit[i]) begin
        m_life[i] = 0;
      end else if (m_life[i] > 0 && frame_tick) begin
        if (m_life[i] == 1) begin
          m_life[i] = 0;
          m_expired[i] = 1'b1;
        end else begin
          m_life[i] = m_life[i] - 1;
        end
      end
    end
    if (go) m_cd = CD;
    else if (frame_tick && m_cd > 0) m_cd = m_cd - 1;
    if (go) m_armed = 0;
    else if (fire && !m_fire_prev) m_armed = 1;
    else if (!fire) m_armed = 0;
    m_fire_prev = fire;
    if (go) begin
      m_lx = ship_x; m_ly = ship_y; m_ls = sin_val; m_lc = cos_val;
    end
  endtask

  // One clock: apply current inputs, advance the model, sample 1 time unit after the edge.
  task automatic tick(input bit ft);
    frame_tick = ft;
    model_step();
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; fire = 1'b0; hit = '0;
    tick(0); tick(0);
    reset = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin tick(1); tick(0); end
  endtask

  task automatic press();
    fire = 1'b1; tick(0); tick(0);
    fire = 1'b0; tick(0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (active !== '0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
    checks++; if (free_count !== CNT_W'(SLOTS)) begin errors++; $display("FAIL reset_free got %0d want %0d", free_count, SLOTS); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if ({launch_x, launch_y, launch_sin, launch_cos} !== '0) begin errors++; $display("FAIL reset_pose got %h want 0", {launch_x, launch_y, launch_sin, launch_cos}); end
    for (int f = 0; f < 5; f++) begin
      tick(1);
      repeat (3) tick(0);
      checks++;
      if ({active, launch, expired, full} !== '0 || free_count !== CNT_W'(SLOTS)) begin
        errors++; $display("FAIL idle_frame%0d act %b lau %b exp %b full %b free %0d want all idle", f, active, launch, expired, full, free_count);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_launch();
    ship_x = 10'd320; ship_y = 9'd240; sin_val = 18'sd0; cos_val = 18'sh1FFFF;
    fire = 1'b1;
    tick(0);
    checks++; if (launch !== '0) begin errors++; $display("FAIL launch_early got %b want 0000", launch); end
    tick(0);
    checks++; if (launch !== 4'b0001) begin errors++; $display("FAIL launch_pulse got %b want 0001", launch); end
    checks++; if (launch_x !== 10'd320 || launch_y !== 9'd240) begin errors++; $display("FAIL launch_xy got %0d,%0d want 320,240", launch_x, launch_y); end
    checks++; if (launch_sin !== 18'sd0 || launch_cos !== 18'sh1FFFF) begin errors++; $display("FAIL launch_sincos got %h,%h want 0,1ffff", launch_sin, launch_cos); end
    checks++; if (active !== 4'b0001 || free_count !== CNT_W'(3)) begin errors++; $display("FAIL launch_active got %b/%0d want 0001/3", active, free_count); end
    ship_x = 10'd7; fire = 1'b0;
    tick(0);
    checks++; if (launch !== '0 || launch_x !== 10'd320) begin errors++; $display("FAIL launch_one_cycle got %b x %0d want 0000 x 320", launch, launch_x); end
    $display("test_single_launch done");
  endtask

  task automatic test_expiry();
    for (int t = 1; t <= LIFE; t++) begin
      tick(1);
      if (t < LIFE) begin
        if (expired !== '0 || active[0] !== 1'b1) begin
          errors++; $display("FAIL early_expiry tick %0d exp %b act %b want 0000 / slot0 active", t, expired, active);
        end
      end else begin
        checks++; if (expired !== 4'b0001) begin errors++; $display("FAIL expiry_pulse got %b want 0001", expired); end
        checks++; if (active !== '0 || free_count !== CNT_W'(SLOTS)) begin errors++; $display("FAIL expiry_active got %b/%0d want 0000/4", active, free_count); end
      end
      tick(0);
      if (t == LIFE) begin
        checks++; if (expired !== '0) begin errors++; $display("FAIL expiry_one_cycle got %b want 0000", expired); end
      end
    end
    checks++;
    $display("test_expiry done");
  endtask

  task automatic test_full_hit();
    do_reset();
    for (int s = 0; s < SLOTS; s++) begin
      press();
      frames(CD + 1);
    end
    checks++; if (active !== 4'b1111 || full !== 1'b1 || free_count !== '0) begin errors++; $display("FAIL fill got %b full %b free %0d want 1111 1 0", active, full, free_count); end
    fire = 1'b1;
    tick(0); tick(0); tick(1); tick(0);
    checks++; if (launch !== '0 || active !== 4'b1111) begin errors++; $display("FAIL full_no_launch got %b act %b want 0000 1111", launch, active); end
    hit = 4'b0100;
    tick(0);
    hit = '0;
    checks++; if (active !== 4'b1011 || full !== 1'b0 || expired !== '0 || launch !== '0) begin errors++; $display("FAIL hit_free got act %b full %b exp %b lau %b want 1011 0 0000 0000", active, full, expired, launch); end
    tick(0);
    checks++; if (launch !== 4'b0100 || active !== 4'b1111 || full !== 1'b1) begin errors++; $display("FAIL relaunch got lau %b act %b full %b want 0100 1111 1", launch, active, full); end
    fire = 1'b0;
    tick(0);
    $display("test_full_hit done");
  endtask

  task automatic test_reset_midflight();
    checks++; if (active === '0) begin errors++; $display("FAIL midflight_setup got %b want nonzero", active); end
    reset = 1'b1;
    tick(1);
    checks++; if (active !== '0 || expired !== '0 || full !== 1'b0 || free_count !== CNT_W'(SLOTS)) begin errors++; $display("FAIL midflight_reset act %b exp %b full %b free %0d want 0000 0000 0 4", active, expired, full, free_count); end
    reset = 1'b0;
    tick(1);
    checks++; if (expired !== '0 || active !== '0) begin errors++; $display("FAIL midflight_after exp %b act %b want 0000 0000", expired, active); end
    $display("test_reset_midflight done");
  endtask

  task automatic test_hit_expiry();
    int guard = 0;
    do_reset();
    press();
    frames(CD + 1);
    press();
    checks++; if (active !== 4'b0011) begin errors++; $display("FAIL two_slots got %b want 0011", active); end
    while (m_life[1] > 1 && guard < 200) begin
      tick(1); tick(0); guard++;
    end
    checks++; if (guard >= 200) begin errors++; $display("FAIL hit_expiry_timeout got %0d frames want <200", guard); end
    hit = 4'b0010;
    tick(1);
    hit = '0;
    checks++; if (active[1] !== 1'b0 || expired !== '0) begin errors++; $display("FAIL hit_vs_expiry act %b exp %b want slot1 idle, exp 0000", active, expired); end
    for (int c = 0; c < 3; c++) begin
      tick(c == 0);
      checks++; if (expired[1] !== 1'b0) begin errors++; $display("FAIL hit_no_expiry cycle %0d exp %b want bit1=0", c, expired); end
    end
    $display("test_hit_expiry done");
  endtask

  task automatic test_hold();
    int n = 0;
    int want;
`ifdef PROJECTILE_AUTOFIRE_EN
    want = 4;
`else
    want = 1;
`endif
    do_reset();
    fire = 1'b1;
    repeat (30) begin
      tick(1); if (launch != '0) n++;
      tick(0); if (launch != '0) n++;
    end
    fire = 1'b0;
    tick(0);
    checks++; if (n != want) begin errors++; $display("FAIL hold_launches got %0d want %0d", n, want); end
    $display("test_hold launches %0d", n);
  endtask

  task automatic test_random();
    logic [VEC_W-1:0] got, exp;
    int bad = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      hit = '0;
      if ($urandom_range(0, 19) == 0) hit[$urandom_range(0, SLOTS-1)] = 1'b1;
      ship_x = X_W'($urandom); ship_y = Y_W'($urandom);
      sin_val = 18'($urandom); cos_val = 18'($urandom);
      tick($urandom_range(0, 2) == 0);
      exp = {m_active(), m_launch, m_expired, CNT_W'(m_free()), (m_free() == 0),
             m_lx, m_ly, m_ls, m_lc};
      got = {active, launch, expired, free_count, full, launch_x, launch_y, launch_sin, launch_cos};
      checks++;
      if (got !== exp) begin
        errors++; bad++;
        if (bad <= 10) $display("FAIL random cycle %0d got %h want %h", c, got, exp);
      end
    end
    reset = 1'b0; hit = '0; fire = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_single_launch();
    test_expiry();
    test_full_hit();
    test_reset_midflight();
    test_hit_expiry();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
